issue_stage: RTL and testbench

- In-order issue stage of the I2O2 core; sits directly upstream of the scoreboard.
- Buffers fetched instructions in a small FIFO and decodes the head instruction.
- Queries the scoreboard with rs1/rs2/rd, then stalls on RAW/WAW pendencies.
- Issues hazard-free instructions to the X (ALU) or M (memory) functional unit and pulses new_line so the scoreboard records the destination.

---
 rtl/i2o2_pkg.sv | 49 ++++
 rtl/issue_fifo.sv | 56 +++++
 rtl/issue_stage.sv | 149 ++++++++++++++
 tb/tb_issue_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2o2_pkg.sv
// Shared types and decode helpers for the I2O2 issue stage.
// Optional ISSUE_STALL_CNT_EN build adds stall counters to issue_stage.
package i2o2_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned UNIT_W = 2;

   localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_ADDI  = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LW    = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_SW    = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 7'b1100011;

   localparam logic [UNIT_W-1:0] UNIT_NONE = 2'b00;
   localparam logic [UNIT_W-1:0] UNIT_X    = 2'b01;
   localparam logic [UNIT_W-1:0] UNIT_M    = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_QUERY = 2'd1,
      S_CHECK = 2'd2,
      S_ISSUE = 2'd3
   } issue_state_t;

   typedef struct packed {
      logic              known;
      logic              uses_rs1;
      logic              uses_rs2;
      logic              writes_rd;
      logic [UNIT_W-1:0] unit;
   } decode_t;

   // Operand usage and target unit per supported opcode.
   function automatic decode_t decode_op(input logic [OPC_W-1:0] opcode);
      decode_t d;
      d = '{known: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, unit: UNIT_NONE};
      case (opcode)
         OP_RTYPE: d = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1, unit: UNIT_X};
         OP_ADDI:  d = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, unit: UNIT_X};
         OP_LW:    d = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, unit: UNIT_M};
         OP_SW:    d = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, unit: UNIT_M};
         OP_BEQ:   d = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, unit: UNIT_X};
         default:  d = '{known: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, unit: UNIT_NONE};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction buffer; pointers wrap modulo DEPTH (power of two).
module issue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             one
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_en;
   logic             pop_en;

   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   assign empty = (count == CW'(0));
   assign full  = (count == CW'(DEPTH));
   assign one   = (count == CW'(1));
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: buffers, decodes, polls the scoreboard, issues to X/M.
// Optional macro ISSUE_STALL_CNT_EN adds stall_cnt/stall_now outputs.
module issue_stage
   import i2o2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned XLEN       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   output logic [4:0]        id_op1,
   output logic [4:0]        id_op2,
   output logic [4:0]        id_dest,
   output logic [6:0]        op_code,
   output logic              new_line,
   input  logic              pendencia_op1,
   input  logic              pendencia_op2,
   input  logic              pendencia_dest,
   input  logic [1:0]        unit_op1,
   input  logic [1:0]        unit_op2,
   input  logic [1:0]        unit_dest,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [XLEN-1:0]   iss_instr,
`ifdef ISSUE_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
   output logic              stall_now,
`endif
   output logic [1:0]        iss_unit
);

   issue_state_t    state_q;
   issue_state_t    state_d;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_one;
   logic            more_left;
   logic [XLEN-1:0] fifo_rdata;
   logic [XLEN-1:0] head;
   decode_t         dec;
   logic            hazard;
   logic            unused_unit_info;

   assign unused_unit_info = ^{unit_op1, unit_op2, unit_dest};

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;

   issue_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (in_instr),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .one   (fifo_one)
   );

   // Head decode; forced to zero while the buffer is empty.
   assign head    = fifo_empty ? '0 : fifo_rdata;
   assign id_op1  = head[19:15];
   assign id_op2  = head[24:20];
   assign id_dest = head[11:7];
   assign op_code = head[6:0];
   assign dec     = decode_op(op_code);

   // x0 never creates a dependency.
   assign hazard = (dec.uses_rs1  && (id_op1  != REG_W'(0)) && pendencia_op1)  ||
                   (dec.uses_rs2  && (id_op2  != REG_W'(0)) && pendencia_op2)  ||
                   (dec.writes_rd && (id_dest != REG_W'(0)) && pendencia_dest);

   assign more_left = !fifo_one || fifo_push;

   assign new_line = rst_n && (state_q == S_ISSUE) && iss_ready &&
                     dec.writes_rd && (id_dest != REG_W'(0));

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_QUERY;
         end
         S_QUERY: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!dec.known) begin
               fifo_pop = 1'b1;
               state_d  = more_left ? S_QUERY : S_IDLE;
            end else if (hazard) begin
               state_d = S_QUERY;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (iss_ready) begin
               fifo_pop = 1'b1;
               state_d  = more_left ? S_QUERY : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Issue payload is captured on entry to S_ISSUE and held until handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         iss_valid <= 1'b0;
         iss_instr <= '0;
         iss_unit  <= UNIT_NONE;
      end else begin
         state_q   <= state_d;
         iss_valid <= (state_d == S_ISSUE);
         if ((state_q == S_CHECK) && (state_d == S_ISSUE)) begin
            iss_instr <= head;
            iss_unit  <= dec.unit;
         end
      end
   end

`ifdef ISSUE_STALL_CNT_EN
   logic stall_hit;
   assign stall_hit = (state_q == S_CHECK) && dec.known && hazard;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         stall_now <= 1'b0;
      end else begin
         stall_now <= stall_hit;
         if (stall_hit) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed self-checking bench for issue_stage.
module tb_issue_stage;

   localparam logic [31:0] I_ADDI5  = 32'h0030_8293; // addi x5,x1,3
   localparam logic [31:0] I_ADD6   = 32'h0072_8333; // add  x6,x5,x7
   localparam logic [31:0] I_SW     = 32'h0051_2023; // sw   x5,0(x2)
   localparam logic [31:0] I_BAD    = 32'h0000_007F;
   localparam logic [31:0] I_ADDI7  = 32'h0070_0393; // addi x7,x0,7

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  id_op1, id_op2, id_dest;
   logic [6:0]  op_code;
   logic        new_line;
   logic        pendencia_op1, pendencia_op2, pendencia_dest;
   logic [1:0]  unit_op1, unit_op2, unit_dest;
   logic        iss_valid;
   logic        iss_ready;
   logic [31:0] iss_instr;
   logic [1:0]  iss_unit;
`ifdef ISSUE_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic        stall_now;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] fill [5];

   issue_stage #(.FIFO_DEPTH(4), .XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instr       (in_instr),
      .id_op1         (id_op1),
      .id_op2         (id_op2),
      .id_dest        (id_dest),
      .op_code        (op_code),
      .new_line       (new_line),
      .pendencia_op1  (pendencia_op1),
      .pendencia_op2  (pendencia_op2),
      .pendencia_dest (pendencia_dest),
      .unit_op1       (unit_op1),
      .unit_op2       (unit_op2),
      .unit_dest      (unit_dest),
      .iss_valid      (iss_valid),
      .iss_ready      (iss_ready),
      .iss_instr      (iss_instr),
`ifdef ISSUE_STALL_CNT_EN
      .stall_cnt      (stall_cnt),
      .stall_now      (stall_now),
`endif
      .iss_unit       (iss_unit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for iss_valid, checks the payload, then lets the handshake edge pass.
   task automatic wait_issue(input string tag, input logic [31:0] exp);
      for (int i = 0; i < 12; i++) begin
         if (iss_valid === 1'b1) break;
         tick();
      end
      chk({tag, "_valid"}, 32'(iss_valid), 32'd1);
      chk({tag, "_instr"}, iss_instr, exp);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; iss_ready = 1'b0;
      pendencia_op1 = 1'b0; pendencia_op2 = 1'b0; pendencia_dest = 1'b0;
      unit_op1 = 2'b00; unit_op2 = 2'b00; unit_dest = 2'b00;
      for (int i = 0; i < 5; i++) fill[i] = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;

      // Reset state
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_iss_valid", 32'(iss_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_id_dest",   32'(id_dest),   32'd0);
      chk("rst_op_code",   32'(op_code),   32'd0);
      chk("rst_new_line",  32'(new_line),  32'd0);
      chk("rst_iss_unit",  32'(iss_unit),  32'd0);
      chk("rst_iss_instr", iss_instr,      32'd0);

      // addi x5,x1,3 with no pendencies: iss_valid 3 edges after push
      in_valid = 1'b1; in_instr = I_ADDI5;
      tick();
      in_valid = 1'b0;
      chk("addi_id_dest", 32'(id_dest), 32'd5);
      chk("addi_id_op1",  32'(id_op1),  32'd1);
      chk("addi_op_code", 32'(op_code), 32'h13);
      tick(); chk("addi_lat1", 32'(iss_valid), 32'd0);
      tick(); chk("addi_lat2", 32'(iss_valid), 32'd0);
      tick(); chk("addi_lat3", 32'(iss_valid), 32'd1);
      chk("addi_unit",  32'(iss_unit), 32'd1);
      chk("addi_instr", iss_instr, I_ADDI5);
      chk("addi_nl_wait", 32'(new_line), 32'd0);
      iss_ready = 1'b1; #1;
      chk("addi_new_line", 32'(new_line), 32'd1);
      chk("addi_nl_dest",  32'(id_dest),  32'd5);
      tick();
      chk("addi_nl_once",  32'(new_line),  32'd0);
      chk("addi_done",     32'(iss_valid), 32'd0);
      iss_ready = 1'b0;

      // add x6,x5,x7 stalled on rs1 pendency
      in_valid = 1'b1; in_instr = I_ADD6;
      tick();
      in_valid = 1'b0; pendencia_op1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stall_no_issue", 32'(iss_valid), 32'd0);
      end
      pendencia_op1 = 1'b0;
      tick();
      chk("stall_release", 32'(iss_valid), 32'd1);
      chk("stall_instr",   iss_instr,      I_ADD6);
      chk("stall_unit",    32'(iss_unit),  32'd1);
`ifdef ISSUE_STALL_CNT_EN
      chk("stall_cnt",     stall_cnt,      32'd2);
`endif
      iss_ready = 1'b1; #1;
      chk("add_new_line", 32'(new_line), 32'd1);
      chk("add_nl_dest",  32'(id_dest),  32'd6);
      tick();
      iss_ready = 1'b0;

      // sw: unit M, no rd so pendencia_dest ignored and no new_line
      in_valid = 1'b1; in_instr = I_SW;
      tick();
      in_valid = 1'b0; pendencia_dest = 1'b1;
      tick(); tick(); tick();
      chk("sw_valid", 32'(iss_valid), 32'd1);
      chk("sw_unit",  32'(iss_unit),  32'd2);
      iss_ready = 1'b1; #1;
      chk("sw_new_line", 32'(new_line), 32'd0);
      tick();
      iss_ready = 1'b0; pendencia_dest = 1'b0;

      // Fill the buffer while the unit back-pressures
      in_valid = 1'b1;
      in_instr = fill[0]; tick();
      in_instr = fill[1]; tick();
      in_instr = fill[2]; tick();
      in_instr = fill[3]; tick();
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_issue0",   32'(iss_valid), 32'd1);
      in_instr = fill[4];
      tick(); tick();
      chk("full_hold_valid", 32'(iss_valid), 32'd1);
      chk("full_hold_instr", iss_instr,      fill[0]);
      chk("full_still_full", 32'(in_ready),  32'd0);
      iss_ready = 1'b1; #1;
      chk("full_new_line", 32'(new_line), 32'd1);
      chk("full_nl_dest",  32'(id_dest),  32'd1);
      tick();
      iss_ready = 1'b0;
      chk("full_ready_after_pop", 32'(in_ready),  32'd1);
      chk("full_next_query",      32'(iss_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("full_fifth_taken", 32'(in_ready), 32'd0);
      iss_ready = 1'b1;
      for (int k = 1; k < 5; k++) wait_issue("drain", fill[k]);
      iss_ready = 1'b0;
      tick();
      chk("drain_empty_ready", 32'(in_ready),  32'd1);
      chk("drain_idle",        32'(iss_valid), 32'd0);

      // Unknown opcode is discarded; following addi issues normally
      in_valid = 1'b1; in_instr = I_BAD;
      tick();
      in_instr = I_ADDI7;
      tick();
      in_valid = 1'b0;
      chk("bad_op_code", 32'(op_code), 32'h7F);
      for (int i = 0; i < 3; i++) begin
         chk("bad_no_valid", 32'(iss_valid), 32'd0);
         chk("bad_no_nl",    32'(new_line),  32'd0);
         tick();
      end
      chk("bad_no_valid_last", 32'(iss_valid), 32'd0);
      tick();
      chk("after_bad_valid", 32'(iss_valid), 32'd1);
      chk("after_bad_instr", iss_instr,      I_ADDI7);
      iss_ready = 1'b1; #1;
      chk("after_bad_nl", 32'(new_line), 32'd1);
      tick();
      iss_ready = 1'b0;

      // Reset while holding an instruction in S_ISSUE
      in_valid = 1'b1; in_instr = I_ADDI5;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("mid_rst_pre_valid", 32'(iss_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid",    32'(iss_valid), 32'd0);
      chk("mid_rst_nl",       32'(new_line),  32'd0);
      chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
      chk("mid_rst_id_dest",  32'(id_dest),   32'd0);
      chk("mid_rst_unit",     32'(iss_unit),  32'd0);
      chk("mid_rst_instr",    iss_instr,      32'd0);
      rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      chk("post_rst_idle", 32'(iss_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
